// File: rtl/cpu_types_pkg.sv
// Shared types for the register file: clear-sequencer states
// and default geometry (DEPTH/WIDTH/NREAD).
package cpu_types_pkg;

   localparam int DEF_DEPTH = 32;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_NREAD = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

endpackage

// File: rtl/regfile_sb_clr.sv
// Clear sequencer: IDLE/CLEAR FSM plus index counter 1..DEPTH-1.
// Ports: i_clk, i_rst (sync, high), i_clr_req in;
//        o_clr_busy, o_clr_start (entry edge), o_clr_idx out.
import cpu_types_pkg::*;

module regfile_sb_clr #(
   parameter  int DEPTH = DEF_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_clr_req,
   output logic          o_clr_busy,
   output logic          o_clr_start,
   output logic [AW-1:0] o_clr_idx
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   clr_state_e    r_state;
   clr_state_e    w_state_nxt;
   logic [AW-1:0] r_cnt;
   logic [AW-1:0] w_cnt_nxt;
   logic          w_start;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Index 0 is hardwired zero, so the sweep starts at 1
   // and takes DEPTH-1 cycles.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_start     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (i_clr_req) begin
               w_state_nxt = CLEAR;
               w_cnt_nxt   = AW'(1);
               w_start     = 1'b1;
            end
         end
         CLEAR: begin
            if (r_cnt == LAST) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + AW'(1);
            end
         end
      endcase
   end

   assign o_clr_busy  = (r_state == CLEAR);
   assign o_clr_start = w_start;
   assign o_clr_idx   = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register scoreboard busy bits and a
// sequential clear. Ports: CLK, RST (sync, high), wen/wsel/wdat
// write, rsel/rdat/rbusy reads, rsv/rsv_sel reserve, clr_req in,
// clr_busy out. Macro REGFILE_SB_BYPASS_EN forwards same-cycle
// writes to matching read ports.
import cpu_types_pkg::*;

module regfile_sb #(
   parameter  int DEPTH = DEF_DEPTH,
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int NREAD = DEF_NREAD,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        wen,
   input  logic [AW-1:0]               wsel,
   input  logic [WIDTH-1:0]            wdat,
   input  logic [NREAD-1:0][AW-1:0]    rsel,
   output logic [NREAD-1:0][WIDTH-1:0] rdat,
   output logic [NREAD-1:0]            rbusy,
   input  logic                        rsv,
   input  logic [AW-1:0]               rsv_sel,
   input  logic                        clr_req,
   output logic                        clr_busy
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0] r_busy;

   logic             w_clr_busy;
   logic             w_clr_start;
   logic [AW-1:0]    w_clr_idx;
   logic             w_wacc;
   logic             w_racc;

   regfile_sb_clr #(
      .DEPTH (DEPTH)
   ) u_clr (
      .i_clk       (CLK),
      .i_rst       (RST),
      .i_clr_req   (clr_req),
      .o_clr_busy  (w_clr_busy),
      .o_clr_start (w_clr_start),
      .o_clr_idx   (w_clr_idx)
   );

   assign w_wacc   = wen && (wsel != '0) && !w_clr_busy;
   assign w_racc   = rsv && (rsv_sel != '0) && !w_clr_busy;
   assign clr_busy = w_clr_busy;

   // A write accepted on the clear-entry edge still lands;
   // the sweep then zeroes it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_wacc) begin
            r_mem[wsel] <= wdat;
         end
         if (w_clr_busy) begin
            r_mem[w_clr_idx] <= '0;
         end
      end
   end

   // Reserve is applied after the write-clear so it wins
   // when both hit the same index.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_busy <= '0;
      end else if (w_clr_start) begin
         r_busy <= '0;
      end else begin
         if (w_wacc) begin
            r_busy[wsel] <= 1'b0;
         end
         if (w_racc) begin
            r_busy[rsv_sel] <= 1'b1;
         end
      end
   end

   always_comb begin
      rdat  = '0;
      rbusy = '0;
      for (int i = 0; i < NREAD; i++) begin
         if (rsel[i] != '0) begin
            rdat[i]  = r_mem[rsel[i]];
            rbusy[i] = r_busy[rsel[i]];
`ifdef REGFILE_SB_BYPASS_EN
            if (w_wacc && (wsel == rsel[i])) begin
               rdat[i]  = wdat;
               rbusy[i] = 1'b0;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: reference model checked every cycle
// plus directed checks of writes, reserves, clear and reset.
module tb_regfile_sb;

   logic             CLK;
   logic             RST;
   logic             wen;
   logic [4:0]       wsel;
   logic [31:0]      wdat;
   logic [1:0][4:0]  rsel;
   logic [1:0][31:0] rdat;
   logic [1:0]       rbusy;
   logic             rsv;
   logic [4:0]       rsv_sel;
   logic             clr_req;
   logic             clr_busy;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   logic [31:0] m_mem  [32];
   bit          m_busy [32];
   int          m_pos = 0;

   regfile_sb dut (
      .CLK      (CLK),
      .RST      (RST),
      .wen      (wen),
      .wsel     (wsel),
      .wdat     (wdat),
      .rsel     (rsel),
      .rdat     (rdat),
      .rbusy    (rbusy),
      .rsv      (rsv),
      .rsv_sel  (rsv_sel),
      .clr_req  (clr_req),
      .clr_busy (clr_busy)
   );

   initial CLK = 0;
   always #5 CLK = ~CLK;

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Reference model: registers/busy as plain arrays, the clear
   // as a position walking 1..31 while nonzero.
   always @(posedge CLK) begin
      if (RST) begin
         for (int k = 0; k < 32; k++) begin
            m_mem[k]  = 0;
            m_busy[k] = 0;
         end
         m_pos = 0;
      end else if (m_pos != 0) begin
         m_mem[m_pos] = 0;
         m_pos = (m_pos == 31) ? 0 : m_pos + 1;
      end else begin
         if (wen && wsel != 0) begin
            m_mem[wsel]  = wdat;
            m_busy[wsel] = 0;
         end
         if (rsv && rsv_sel != 0) m_busy[rsv_sel] = 1;
         if (clr_req) begin
            for (int k = 0; k < 32; k++) m_busy[k] = 0;
            m_pos = 1;
         end
      end
   end

   int          c_idx;
   logic [31:0] c_e;
   logic        c_b;

   always @(negedge CLK) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            c_idx = int'(rsel[i]);
            c_e   = (c_idx == 0) ? 32'h0 : m_mem[c_idx];
            c_b   = (c_idx == 0) ? 1'b0 : m_busy[c_idx];
`ifdef REGFILE_SB_BYPASS_EN
            if (m_pos == 0 && wen && wsel != 0
                && int'(wsel) == c_idx) begin
               c_e = wdat;
               c_b = 1'b0;
            end
`endif
            chk($sformatf("model_rdat%0d", i), rdat[i], c_e);
            chk($sformatf("model_rbusy%0d", i),
                {31'b0, rbusy[i]}, {31'b0, c_b});
         end
         chk("model_clr_busy", {31'b0, clr_busy},
             {31'b0, m_pos != 0});
      end
   end

   task automatic sweep_zero(string nm);
      for (int k = 0; k < 32; k++) begin
         rsel[0] = 5'(k);
         rsel[1] = 5'(31 - k);
         #1;
         chk($sformatf("%s_rdat0_%0d", nm, k), rdat[0], 32'h0);
         chk($sformatf("%s_rdat1_%0d", nm, k), rdat[1], 32'h0);
         chk($sformatf("%s_rbusy_%0d", nm, k),
             {30'b0, rbusy}, 32'h0);
      end
   endtask

   task automatic load_all();
      for (int k = 1; k < 32; k++) begin
         wen  = 1;
         wsel = 5'(k);
         wdat = 32'h1000_0000 + k * 3 + 1;
         step();
      end
      wen = 0;
   endtask

   int n;

   initial begin
      RST = 1; wen = 0; wsel = 0; wdat = 0;
      rsel = '0; rsv = 0; rsv_sel = 0; clr_req = 0;
      step();
      chk_en = 1;
      step();
      RST = 0;
      #1;
      chk("reset_clr_busy", {31'b0, clr_busy}, 32'h0);
      chk("reset_rdat0", rdat[0], 32'h0);

      // write 5, read back next cycle
      wen = 1; wsel = 5; wdat = 32'hDEADBEEF; rsel[0] = 5;
      #1;
`ifdef REGFILE_SB_BYPASS_EN
      chk("wr5_same_cycle", rdat[0], 32'hDEADBEEF);
`else
      chk("wr5_same_cycle", rdat[0], 32'h0);
`endif
      step();
      wen = 0;
      #1;
      chk("wr5_next_cycle", rdat[0], 32'hDEADBEEF);

      // writes to index 0 are discarded
      wen = 1; wsel = 0; wdat = 32'hFFFFFFFF; rsel[1] = 0;
      #1;
      chk("r0_during_wr", rdat[1], 32'h0);
      step();
      wen = 0;
      #1;
      chk("r0_after_wr", rdat[1], 32'h0);

      // reserve / release / reserve-wins
      rsv = 1; rsv_sel = 7;
      step();
      rsv = 0; rsel[0] = 7;
      #1;
      chk("rsv7_busy", {31'b0, rbusy[0]}, 32'h1);
      wen = 1; wsel = 7; wdat = 32'h77;
      step();
      wen = 0;
      #1;
      chk("wr7_release", {31'b0, rbusy[0]}, 32'h0);
      chk("wr7_data", rdat[0], 32'h77);
      rsv = 1; rsv_sel = 7; wen = 1; wsel = 7; wdat = 32'h99;
      step();
      rsv = 0; wen = 0;
      #1;
      chk("rsv_wins_busy", {31'b0, rbusy[0]}, 32'h1);
      chk("rsv_wins_data", rdat[0], 32'h99);

      // same-cycle read of a register being written
      wen = 1; wsel = 3; wdat = 32'hAAAA;
      step();
      wdat = 32'h1234; rsel[0] = 3;
      #1;
`ifdef REGFILE_SB_BYPASS_EN
      chk("bypass_rd3", rdat[0], 32'h1234);
`else
      chk("bypass_rd3", rdat[0], 32'hAAAA);
`endif
      step();
      wen = 0;
      #1;
      chk("after_wr3", rdat[0], 32'h1234);

      // full clear; write on entry edge, write during clear
      load_all();
      rsv = 1; rsv_sel = 12;
      step();
      rsv = 0; rsel[0] = 12; rsel[1] = 31;
      #1;
      chk("pre_clr_busy12", {31'b0, rbusy[0]}, 32'h1);
      chk("pre_clr_rd31", rdat[1], 32'h1000_005E);
      clr_req = 1; wen = 1; wsel = 4; wdat = 32'h4444;
      step();
      clr_req = 0; wen = 0;
      n = 0;
      for (int c = 0; c < 100; c++) begin
         #1;
         if (!clr_busy) break;
         n++;
         wen = (c == 20);
         wsel = 3; wdat = 32'h5555;
         step();
      end
      wen = 0;
      chk("clr_cycles", n, 31);
      sweep_zero("after_clr");

      // reset in the 10th clear cycle
      load_all();
      rsv = 1; rsv_sel = 6;
      step();
      rsv = 0;
      clr_req = 1;
      step();
      clr_req = 0;
      repeat (9) step();
      #1;
      chk("mid_clr_busy", {31'b0, clr_busy}, 32'h1);
      RST = 1;
      step();
      RST = 0;
      #1;
      chk("rst_abort_clr", {31'b0, clr_busy}, 32'h0);
      sweep_zero("after_rst");

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
